seg7_mux: RTL

Parametrised multiplexed 7-segment display driver for the board-level debug/status display. It scans `N_DIGITS` common-anode digits from a packed hex word and adds several controls: per-digit decimal points and blanking, frame-synchronous double-buffered updates, anti-ghosting guard time and PWM brightness. It sits between any register/status source and the board `an`/`ca` pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_mux_lzb.sv | 18 +
 rtl/seg7_mux.sv | 71 +++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, blank constant and active-low hex font for seg7_mux.
package seg7_pkg;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_OFF = 8'hFF;
  localparam int DP_BIT = 0;
  function automatic seg_t seg7_font(input logic [3:0] hex);
    case (hex)
      4'h0: return 8'h03;
      4'h1: return 8'h9F;
      4'h2: return 8'h25;
      4'h3: return 8'h0D;
      4'h4: return 8'h99;
      4'h5: return 8'h49;
      4'h6: return 8'h41;
      4'h7: return 8'h1F;
      4'h8: return 8'h01;
      4'h9: return 8'h09;
      4'hA: return 8'h11;
      4'hB: return 8'hC1;
      4'hC: return 8'h63;
      4'hD: return 8'h85;
      4'hE: return 8'h61;
      default: return 8'h71;
    endcase
  endfunction
endpackage

// File: rtl/seg7_mux_lzb.sv
// seg7_lzb: leading-zero suppression mask from the top digit down; digit 0 always kept.
module seg7_lzb #(
  parameter int N_DIGITS = 8
) (
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   mask
);
  logic lead;
  always_comb begin
    mask = '0;
    lead = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lead = lead && data[4*i+:4] == 4'h0 && !dp[i];
      mask[i] = lead && i != 0;
    end
  end
endmodule

// File: rtl/seg7_mux.sv
// seg7_mux: multiplexed common-anode 7-seg driver with double buffering, guard time and PWM; SEG7_MUX_LZB_EN adds leading-zero blanking.
module seg7_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV_W    = 17,
  parameter int GUARD    = 64,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic                  frame,
  output logic [N_DIGITS-1:0]   an,
  output seg_t                  ca
);
  localparam int CW = $clog2(N_DIGITS);
  logic [DIV_W-1:0] pre;
  logic [CW-1:0] cur;
  logic pending;
  logic [4*N_DIGITS-1:0] stg_data, act_data;
  logic [N_DIGITS-1:0] stg_dp, stg_blank, act_dp, act_blank, eff_blank;
  logic tick, last, bnd, lit;
  seg_t glyph;
`ifdef SEG7_MUX_LZB_EN
  logic [N_DIGITS-1:0] lzb_mask;
  seg7_lzb #(.N_DIGITS(N_DIGITS)) u_lzb (.data(act_data), .dp(act_dp), .mask(lzb_mask));
  assign eff_blank = act_blank | lzb_mask;
`else
  assign eff_blank = act_blank;
`endif
  assign tick = &pre;
  assign last = cur == CW'(N_DIGITS - 1);
  assign bnd  = tick && last;
  assign lit  = pre >= DIV_W'(GUARD) && (&bright || pre[DIV_W-1 -: BRIGHT_W] < bright) && !eff_blank[cur];
  always_comb begin
    glyph = seg7_font(act_data[4*cur+:4]);
    glyph[DP_BIT] = ~act_dp[cur];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      cur       <= '0;
      pending   <= 1'b0;
      stg_data  <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_blank <= '1;
      frame     <= 1'b0;
      an        <= '1;
      ca        <= SEG_OFF;
    end else begin
      pre <= pre + 1'b1;
      if (tick) cur <= last ? '0 : cur + 1'b1;
      if (load) {stg_data, stg_dp, stg_blank} <= {data, dp, blank};
      // a load landing on the boundary bypasses staging so it is not a frame late
      if (bnd && (load || pending))
        {act_data, act_dp, act_blank} <= load ? {data, dp, blank} : {stg_data, stg_dp, stg_blank};
      pending <= bnd ? 1'b0 : (load || pending);
      frame   <= bnd;
      an      <= lit ? ~(N_DIGITS'(1) << cur) : '1;
      ca      <= lit ? glyph : SEG_OFF;
    end
  end
endmodule
